// File: rtl/ifu_if.sv
// ifu_if: bundle between the fetch unit and the rest of the core.
//   master modport: core/bench side. It drives the control inputs (stall,
//                   beq, zero, jump, jr, rs_val) and the program-load port
//                   (load_en, load_addr, load_data). It observes the fetch
//                   outputs.
//   slave modport:  fetch unit side. It drives instr, op, pc, pc_plus4,
//                   fetch_err and fetch_cnt.
// No valid/ready handshake is involved. One instruction is fetched every
// cycle. The control inputs describe the instruction currently shown on
// instr, and they take effect at the next rising edge.
interface ifu_if #(
    parameter int IM_AW = 10
);
    logic             stall;
    logic             beq;
    logic             zero;
    logic             jump;
    logic             jr;
    logic [31:0]      rs_val;
    logic             load_en;
    logic [IM_AW-1:0] load_addr;
    logic [31:0]      load_data;

    logic [31:0]      instr;
    logic [5:0]       op;
    logic [31:0]      pc;
    logic [31:0]      pc_plus4;
    logic             fetch_err;
    logic [31:0]      fetch_cnt;

    modport master (
        output stall, beq, zero, jump, jr, rs_val,
        output load_en, load_addr, load_data,
        input  instr, op, pc, pc_plus4, fetch_err, fetch_cnt
    );

    modport slave (
        input  stall, beq, zero, jump, jr, rs_val,
        input  load_en, load_addr, load_data,
        output instr, op, pc, pc_plus4, fetch_err, fetch_cnt
    );
endinterface

// File: rtl/ifu.sv
// ifu: instruction fetch unit for the single-cycle MIPS core.
//   It holds the PC and a word-addressed instruction memory of 2**IM_AW words.
//   It presents the instruction at pc combinationally.
//   It picks the next PC with this priority:
//     stall > jr > jump > taken beq > pc+4.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high; pc <= PC_RESET, fetch_cnt <= 0
//          (the IM keeps its contents)
//   bus    ifu_if.slave; carries the control inputs, the load port and the
//          fetch outputs (instr, op, pc, pc_plus4, fetch_err, fetch_cnt)
module ifu #(
    parameter int          IM_AW    = 10,
    parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
    input  logic  clk,
    input  logic  reset,
    ifu_if.slave  bus
);
    // Byte size of the IM window. It is kept 33 bits wide so that the
    // comparison below cannot wrap.
    localparam logic [32:0] IM_BYTES = 33'(4) << IM_AW;

    logic [31:0]      im [2**IM_AW];
    logic [31:0]      pc_q;
    logic [31:0]      cnt_q;
    logic [31:0]      pc_plus4;
    logic [31:0]      offset;
    logic             fetch_err;
    logic [IM_AW-1:0] idx;
    logic [31:0]      instr;
    logic [31:0]      br_off;
    logic [31:0]      next_pc;

    assign pc_plus4 = pc_q + 32'd4;

    // When pc is below PC_RESET, the subtraction wraps to a large value.
    // A single unsigned compare therefore covers both edges of the window.
    assign offset    = pc_q - PC_RESET;
    assign fetch_err = (pc_q[1:0] != 2'b00) || ({1'b0, offset} >= IM_BYTES);
    assign idx       = offset[IM_AW+1:2];
    assign instr     = fetch_err ? 32'h0 : im[idx];

    assign br_off = {{14{instr[15]}}, instr[15:0], 2'b00};

    always_comb begin
        next_pc = pc_plus4;
        if (bus.stall)
            next_pc = pc_q;
        else if (bus.jr)
            next_pc = bus.rs_val;
        else if (bus.jump)
            next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
        else if (bus.beq && bus.zero)
            next_pc = pc_plus4 + br_off;
    end

    // The load port writes independently of reset and stall.
    always_ff @(posedge clk) begin
        if (bus.load_en)
            im[bus.load_addr] <= bus.load_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q  <= PC_RESET;
            cnt_q <= 32'd0;
        end else if (!bus.stall) begin
            pc_q  <= next_pc;
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign bus.instr     = instr;
    assign bus.op        = instr[31:26];
    assign bus.pc        = pc_q;
    assign bus.pc_plus4  = pc_plus4;
    assign bus.fetch_err = fetch_err;
    assign bus.fetch_cnt = cnt_q;
endmodule

// File: tb/tb_ifu.sv
module tb_ifu;
    localparam int          IM_AW    = 10;
    localparam int          IM_WORDS = 1 << IM_AW;
    localparam logic [31:0] PC_RESET = 32'h0000_3000;

    logic clk;
    logic reset;

    ifu_if #(.IM_AW(IM_AW)) bus ();

    ifu #(.IM_AW(IM_AW), .PC_RESET(PC_RESET)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [31:0] m_im [IM_WORDS];
    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    int total;
    int bad;

    function automatic logic m_err(input logic [31:0] p);
        return (p % 4 != 0) || (p < PC_RESET) || (p >= PC_RESET + 4 * IM_WORDS);
    endfunction

    function automatic logic [31:0] m_instr(input logic [31:0] p);
        if (m_err(p)) return 32'h0;
        return m_im[int'((p - PC_RESET) / 4)];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [31:0] ins;
        ins = m_instr(m_pc);
        chk("pc", bus.pc, m_pc);
        chk("pc_plus4", bus.pc_plus4, m_pc + 32'd4);
        chk("instr", bus.instr, ins);
        chk("op", {26'd0, bus.op}, {26'd0, ins[31:26]});
        chk("fetch_err", {31'd0, bus.fetch_err}, {31'd0, m_err(m_pc)});
        chk("fetch_cnt", bus.fetch_cnt, m_cnt);
    endtask

    // One rising edge. The model's next state is computed from the inputs as
    // they stand before the edge. The outputs are then checked 1 time unit
    // after the edge.
    task automatic tick(input bit do_check);
        logic [31:0] ins;
        logic [31:0] p4;
        logic [31:0] npc;
        ins = m_instr(m_pc);
        p4  = m_pc + 32'd4;
        if (bus.stall)                npc = m_pc;
        else if (bus.jr)              npc = bus.rs_val;
        else if (bus.jump)            npc = {p4[31:28], ins[25:0], 2'b00};
        else if (bus.beq && bus.zero) npc = p4 + 32'($signed(ins[15:0])) * 32'd4;
        else                          npc = p4;
        @(posedge clk);
        if (bus.load_en) m_im[int'(bus.load_addr)] = bus.load_data;
        if (reset) begin
            m_pc  = PC_RESET;
            m_cnt = 0;
        end else if (!bus.stall) begin
            m_pc  = npc;
            m_cnt = m_cnt + 1;
        end
        #1;
        if (do_check) check_all();
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_ctrl(input logic st, input logic bq, input logic zr,
                            input logic jp, input logic j_r, input logic [31:0] rs);
        bus.stall  = st;
        bus.beq    = bq;
        bus.zero   = zr;
        bus.jump   = jp;
        bus.jr     = j_r;
        bus.rs_val = rs;
    endtask

    task automatic set_load(input logic en, input logic [IM_AW-1:0] a, input logic [31:0] d);
        bus.load_en   = en;
        bus.load_addr = a;
        bus.load_data = d;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        total = 0;
        bad   = 0;
        m_pc  = PC_RESET;
        m_cnt = 0;
        reset = 1'b1;
        set_ctrl(0, 0, 0, 0, 0, 32'h0);
        set_load(0, '0, 32'h0);

        // Fill the IM while reset is held. The directed tests use the
        // words placed at indices 0 and 2.
        for (int i = 0; i < IM_WORDS; i++) begin
            if (i == 0)      set_load(1, IM_AW'(i), 32'h3401_0005);
            else if (i == 2) set_load(1, IM_AW'(i), 32'h1000_FFFE);
            else             set_load(1, IM_AW'(i), $urandom);
            tick(0);
        end
        set_load(0, '0, 32'h0);
        tick(1);
        reset = 1'b0;

        // 1: reset state
        chk("rst_pc", bus.pc, 32'h3000);
        chk("rst_op", {26'd0, bus.op}, 32'h0000_000D);
        chk("rst_cnt", bus.fetch_cnt, 32'd0);
        chk("rst_err", {31'd0, bus.fetch_err}, 32'd0);

        // 2: free run, then stall
        repeat (5) tick(1);
        chk("run_pc", bus.pc, 32'h3014);
        chk("run_cnt", bus.fetch_cnt, 32'd5);
        bus.stall = 1'b1;
        repeat (2) tick(1);
        chk("stall_pc", bus.pc, 32'h3014);
        chk("stall_cnt", bus.fetch_cnt, 32'd5);
        bus.stall = 1'b0;

        // 3: beq at 0x3008 with imm -2, taken and not taken
        reset = 1'b1; tick(1); reset = 1'b0;
        repeat (2) tick(1);
        chk("beq_at", bus.pc, 32'h3008);
        set_ctrl(0, 1, 1, 0, 0, 32'h0); tick(1);
        chk("beq_taken", bus.pc, 32'h3004);
        set_ctrl(0, 0, 0, 0, 0, 32'h0);
        reset = 1'b1; tick(1); reset = 1'b0;
        repeat (2) tick(1);
        set_ctrl(0, 1, 0, 0, 0, 32'h0); tick(1);
        chk("beq_fall", bus.pc, 32'h300C);
        set_ctrl(0, 0, 0, 0, 0, 32'h0);

        // 4: jump, then jump and jr together. The load happens during reset.
        reset = 1'b1; set_load(1, '0, 32'h0800_0C10); tick(1);
        reset = 1'b0; set_load(0, '0, 32'h0);
        chk("ld_in_rst", bus.instr, 32'h0800_0C10);
        set_ctrl(0, 0, 0, 1, 0, 32'h0); tick(1);
        chk("j_pc", bus.pc, 32'h3040);
        set_ctrl(0, 0, 0, 0, 0, 32'h0);
        reset = 1'b1; tick(1); reset = 1'b0;
        set_ctrl(0, 1, 1, 1, 1, 32'h3100); tick(1);
        chk("jr_wins", bus.pc, 32'h3100);

        // 5: fetch_err boundaries
        set_ctrl(0, 0, 0, 0, 1, 32'h3002); tick(1);
        chk("unal_err", {31'd0, bus.fetch_err}, 32'd1);
        chk("unal_instr", bus.instr, 32'h0);
        set_ctrl(0, 0, 0, 0, 1, 32'h2FFC); tick(1);
        chk("low_err", {31'd0, bus.fetch_err}, 32'd1);
        set_ctrl(0, 0, 0, 0, 1, 32'h4000); tick(1);
        chk("high_err", {31'd0, bus.fetch_err}, 32'd1);
        set_ctrl(0, 0, 0, 0, 1, 32'h3FFC); tick(1);
        chk("last_ok", {31'd0, bus.fetch_err}, 32'd0);
        set_ctrl(0, 0, 0, 0, 0, 32'h0);

        // 6: load the current index while stalled, then a mid-run reset
        reset = 1'b1; tick(1); reset = 1'b0;
        set_ctrl(1, 0, 0, 0, 0, 32'h0);
        set_load(1, '0, 32'h0800_0C00);
        #1;
        chk("ld_before", bus.instr, 32'h0800_0C10);
        tick(1);
        chk("ld_after", bus.instr, 32'h0800_0C00);
        set_load(0, '0, 32'h0);
        set_ctrl(0, 0, 0, 0, 0, 32'h0);
        repeat (3) tick(1);
        reset = 1'b1; tick(1); reset = 1'b0;
        chk("mid_rst_pc", bus.pc, 32'h3000);
        chk("im_kept", bus.instr, 32'h0800_0C00);

        // Random phase
        for (int n = 0; n < 600; n++) begin
            logic [31:0] rs;
            case ($urandom_range(0, 9))
                0:       rs = $urandom;
                1:       rs = PC_RESET + 32'($urandom_range(0, IM_WORDS * 4 - 1));
                default: rs = PC_RESET + 32'($urandom_range(0, IM_WORDS - 1)) * 4;
            endcase
            set_ctrl($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
                     1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0,
                     $urandom_range(0, 9) == 0, rs);
            set_load($urandom_range(0, 3) == 0, IM_AW'($urandom_range(0, IM_WORDS - 1)), $urandom);
            reset = ($urandom_range(0, 39) == 0);
            tick(1);
        end
        reset = 1'b0;
        set_ctrl(0, 0, 0, 0, 0, 32'h0);
        set_load(0, '0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
